// File: rtl/mano_loader.sv
// Program-load front end for the Mano CPU: decodes A5-framed address/word streams onto the CPU
// load port and releases execution on a 5A byte. Define LOADER_CHECKSUM_EN for per-frame checksum.
module mano_loader #(
    parameter logic [11:0] MEM_TOP = 12'hFE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        run_code,
    output logic [11:0] address,
    output logic [15:0] code,
    output logic        busy,
    output logic        err,
    output logic [12:0] words_loaded
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAddrHi = 3'd1;
    localparam logic [2:0] StAddrLo = 3'd2;
    localparam logic [2:0] StCount  = 3'd3;
    localparam logic [2:0] StDataHi = 3'd4;
    localparam logic [2:0] StDataLo = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] StCsum   = 3'd6;
`endif
    localparam logic [2:0] StRun    = 3'd7;

    localparam logic [7:0]  FrameStart = 8'hA5;
    localparam logic [7:0]  RunStart   = 8'h5A;
    localparam logic [12:0] WordsMax   = 13'h1FFF;

    logic [2:0]  state_q, state_d;
    logic [11:0] tgt_q, tgt_d;          // next target address inside a frame
    logic [8:0]  cnt_q, cnt_d;          // words remaining, 256 encoded as 9'd256
    logic [7:0]  hi_q, hi_d;
    logic [11:0] address_q, address_d;
    logic [15:0] code_q, code_d;
    logic        err_q, err_d;
    logic [12:0] words_q, words_d;
    logic        accept;
    logic [2:0]  frame_end_st;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  csum_next;

    assign csum_next    = csum_q + rx_data;
    assign frame_end_st = StCsum;
`else
    assign frame_end_st = StIdle;
`endif

    assign rx_ready     = (state_q != StRun);
    assign run_code     = (state_q == StRun);
    assign busy         = (state_q != StIdle) && (state_q != StRun);
    assign err          = err_q;
    assign address      = address_q;
    assign code         = code_q;
    assign words_loaded = words_q;
    assign accept       = rx_valid && rx_ready;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        address_d = address_q;
        code_d    = code_q;
        err_d     = err_q;
        words_d   = words_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (rx_data == FrameStart) begin
                        state_d = StAddrHi;
                    end else if (rx_data == RunStart) begin
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StAddrHi: begin
                    tgt_d[11:8] = rx_data[3:0];
`ifdef LOADER_CHECKSUM_EN
                    csum_d      = rx_data;
`endif
                    state_d     = StAddrLo;
                end
                StAddrLo: begin
                    tgt_d[7:0] = rx_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_next;
`endif
                    state_d    = StCount;
                end
                StCount: begin
                    cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_next;
`endif
                    state_d = StDataHi;
                end
                StDataHi: begin
                    hi_d    = rx_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_next;
`endif
                    state_d = StDataLo;
                end
                StDataLo: begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_next;
`endif
                    // Out-of-range words are dropped but the frame keeps consuming bytes.
                    if (tgt_q <= MEM_TOP) begin
                        address_d = tgt_q;
                        code_d    = {hi_q, rx_data};
                        if (words_q != WordsMax) begin
                            words_d = words_q + 13'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    tgt_d = tgt_q + 12'd1;
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = frame_end_st;
                    end else begin
                        state_d = StDataHi;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCsum: begin
                    if (csum_next != 8'h00) begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
`endif
                StRun: begin
                    state_d = StRun;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tgt_q     <= 12'h000;
            cnt_q     <= 9'd0;
            hi_q      <= 8'h00;
            address_q <= 12'h000;
            code_q    <= 16'h0000;
            err_q     <= 1'b0;
            words_q   <= 13'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            address_q <= address_d;
            code_q    <= code_d;
            err_q     <= err_d;
            words_q   <= words_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_mano_loader.sv
// Bench for mano_loader: frame-level reference model compared every cycle, plus literal pins.
module tb_mano_loader;

    localparam logic [11:0] MemTop = 12'hFE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        run_code;
    logic [11:0] address;
    logic [15:0] code;
    logic        busy;
    logic        err;
    logic [12:0] words_loaded;

    int checks = 0;
    int errors = 0;
    bit in_reset = 1'b1;

    // Expected outputs as implied by the frames sent so far.
    logic [11:0] exp_address;
    logic [15:0] exp_code;
    logic [12:0] exp_words;
    logic        exp_err, exp_busy, exp_run;
    logic [15:0] wbuf [256];

    mano_loader #(.MEM_TOP(MemTop)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .run_code     (run_code),
        .address      (address),
        .code         (code),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!in_reset) begin
            chk("rx_ready", {31'd0, rx_ready}, {31'd0, !exp_run});
            chk("run_code", {31'd0, run_code}, {31'd0, exp_run});
            chk("address", {20'd0, address}, {20'd0, exp_address});
            chk("code", {16'd0, code}, {16'd0, exp_code});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("words_loaded", {19'd0, words_loaded}, {19'd0, exp_words});
        end
    end

    task automatic do_reset();
        in_reset = 1'b1;
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_address = 12'h000;
        exp_code = 16'h0000;
        exp_words = 13'd0;
        exp_err = 1'b0;
        exp_busy = 1'b0;
        exp_run = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends one load frame of n words from wbuf; bad is added to the correct checksum byte.
    task automatic send_frame(input logic [3:0] junk, input logic [11:0] a, input int n,
                              input logic [7:0] bad);
        logic [7:0]  sum;
        logic [11:0] t;
        logic [7:0]  cnt_byte;
        send_byte(8'hA5);
        exp_busy = 1'b1;
        send_byte({junk, a[11:8]});
        sum = {junk, a[11:8]};
        send_byte(a[7:0]);
        sum = sum + a[7:0];
        cnt_byte = n[7:0];
        send_byte(cnt_byte);
        sum = sum + cnt_byte;
        t = a;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i][15:8]);
            send_byte(wbuf[i][7:0]);
            sum = sum + wbuf[i][15:8] + wbuf[i][7:0];
            if (t <= MemTop) begin
                exp_address = t;
                exp_code = wbuf[i];
                if (exp_words != 13'h1FFF) exp_words = exp_words + 13'd1;
            end else begin
                exp_err = 1'b1;
            end
            t = t + 12'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum + bad);
        if (bad != 8'h00) exp_err = 1'b1;
`else
        if (bad != 8'h00) sum = sum + bad;
`endif
        exp_busy = 1'b0;
    endtask

    initial begin
        exp_address = 12'h000;
        exp_code = 16'h0000;
        exp_words = 13'd0;
        exp_err = 1'b0;
        exp_busy = 1'b0;
        exp_run = 1'b0;
        #2;
        do_reset();
        chk("reset_ready", {31'd0, rx_ready}, 32'd1);
        chk("reset_words", {19'd0, words_loaded}, 32'd0);
        chk("reset_addr", {20'd0, address}, 32'd0);

        // Two words at 0x100.
        wbuf[0] = 16'h7200;
        wbuf[1] = 16'h7001;
        send_frame(4'h0, 12'h100, 2, 8'h00);
        chk("f1_addr", {20'd0, address}, 32'h101);
        chk("f1_code", {16'd0, code}, 32'h7001);
        chk("f1_words", {19'd0, words_loaded}, 32'd2);
        chk("f1_err", {31'd0, err}, 32'd0);
        chk("f1_busy", {31'd0, busy}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Same frame with a wrong checksum: words still land, err sticks.
        send_frame(4'h0, 12'h100, 2, 8'h01);
        chk("bad_csum_err", {31'd0, err}, 32'd1);
        chk("bad_csum_words", {19'd0, words_loaded}, 32'd4);
        chk("bad_csum_busy", {31'd0, busy}, 32'd0);
`endif

        // Bad header byte, then a valid frame with a junk upper address nibble.
        do_reset();
        send_byte(8'h3C);
        exp_err = 1'b1;
        chk("hdr_err", {31'd0, err}, 32'd1);
        chk("hdr_addr", {20'd0, address}, 32'd0);
        wbuf[0] = 16'hBEEF;
        send_frame(4'hC, 12'h234, 1, 8'h00);
        chk("after_hdr_addr", {20'd0, address}, 32'h234);
        chk("after_hdr_code", {16'd0, code}, 32'hBEEF);

        // Range boundary: FE1 accepted, FE2 dropped.
        do_reset();
        wbuf[0] = 16'h1111;
        wbuf[1] = 16'h2222;
        send_frame(4'h0, 12'hFE1, 2, 8'h00);
        chk("top_addr", {20'd0, address}, 32'hFE1);
        chk("top_code", {16'd0, code}, 32'h1111);
        chk("top_words", {19'd0, words_loaded}, 32'd1);
        chk("top_err", {31'd0, err}, 32'd1);

        // Address wrap: FFF dropped, then 000 loaded.
        wbuf[0] = 16'h3333;
        wbuf[1] = 16'h4444;
        send_frame(4'h0, 12'hFFF, 2, 8'h00);
        chk("wrap_addr", {20'd0, address}, 32'h000);
        chk("wrap_code", {16'd0, code}, 32'h4444);
        chk("wrap_words", {19'd0, words_loaded}, 32'd2);

        // Reset in the middle of a frame, right after a DATA_HI byte.
        send_byte(8'hA5);
        exp_busy = 1'b1;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h72);
        do_reset();
        chk("mid_rst_words", {19'd0, words_loaded}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_run", {31'd0, run_code}, 32'd0);
        wbuf[0] = 16'hA5A5;
        send_frame(4'h0, 12'h010, 1, 8'h00);
        chk("fresh_addr", {20'd0, address}, 32'h010);
        chk("fresh_code", {16'd0, code}, 32'hA5A5);

        // Saturation: 33 full 256-word frames exceed 8191.
        for (int f = 0; f < 33; f++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = {f[7:0], i[7:0]};
            send_frame(4'h0, 12'h000, 256, 8'h00);
        end
        chk("sat_words", {19'd0, words_loaded}, 32'h1FFF);
        chk("sat_addr", {20'd0, address}, 32'h0FF);
        chk("sat_code", {16'd0, code}, 32'h20FF);

        // Release the CPU; later bytes are refused.
        send_byte(8'h5A);
        exp_run = 1'b1;
        chk("run_high", {31'd0, run_code}, 32'd1);
        chk("run_ready", {31'd0, rx_ready}, 32'd0);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h00);
        chk("run_ignore_err", {31'd0, err}, 32'd0);
        chk("run_hold_addr", {20'd0, address}, 32'h0FF);
        do_reset();
        chk("run_reset", {31'd0, run_code}, 32'd0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
